gate_sequencer: RTL
===================

# gate_sequencer

Sequencer that drives one two-input logic gate lane (outputs m=AND, n=OR, p=NOT a, q=XOR) through all four input combinations. It dwells a programmable number of cycles on each combination, captures the four gate outputs, and optionally self-checks them against the expected truth table. It sits between the board clock/switch logic and a gate lane, replacing manual switch stimulus with an automatic exerciser. Its outputs drive the LEDs and a status indicator.

## Interface
- DWELL, 50_000_000: cycles spent on each input combination; legal range 2..2^DIV_W-1
- DIV_W, 26: width of the dwell counter
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a sweep
- stop  in  1  synchronous abort
- loop  in  1  0 = single pass, 1 = repeat sweeps until stop; sampled when start is accepted
- a_out, b_out  out  1  registered stimulus to the gate lane's a/b inputs
- m_in, n_in, p_in, q_in  in  1  gate lane outputs (combinational from a_out/b_out)
- result  out  4  last captured {m,n,p,q}
- step  out  2  current combination index; a_out=step[1], b_out=step[0]
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse at end of a single-pass sweep
- err  out  1  sticky mismatch flag
- err_step  out  2  index of the first mismatching combination

## Operation
- States:
  - IDLE: a_out=b_out=0, busy=0.
  - APPLY: busy=1, stimulus = step.
  - DONE: busy=0, done=1, lasts one cycle, then IDLE.
- IDLE + start (and stop low) -> APPLY.
  - On this transition: step=0, dwell counter=0, loop latched, err and err_step cleared.
  - result is not cleared.
- APPLY: the dwell counter increments each cycle. The cycle with counter==DWELL-1 is the sample cycle:
  - result <= {m_in,n_in,p_in,q_in} at the end of that cycle.
  - The counter returns to 0.
  - If step<3: step increments and the state stays in APPLY.
  - If step==3 and latched loop=1: step wraps to 0 and the state stays in APPLY.
  - If step==3 and latched loop=0: -> DONE, and step stays 3.
- Self-check (see Configuration): expected values for step={a,b} are m=a&b, n=a|b, p=~a, q=a^b.
  - A mismatch on the sample cycle sets err.
  - err_step is loaded only if err was previously 0, so it records the first failure.
- stop in any state -> IDLE on the next edge.
  - done is not pulsed, result is not updated that cycle, and step resets to 0.
  - stop outranks start and the sample cycle when they occur together.
- start while busy or in DONE is ignored.
- rst forces IDLE from any state, including mid-sweep. Reset value of all outputs and counters: 0.

## Timing
- All outputs are registered.
- start accepted on cycle 0: APPLY, busy=1, and a_out/b_out=00 are visible from cycle 1.
- Combination k (0..3) is applied on cycles 1+k·DWELL .. k·DWELL+DWELL. Its sample cycle is the last of these. result shows the captured value from the next cycle.
- Single pass: done=1 and busy=0 on cycle 1+4·DWELL; IDLE from cycle 2+4·DWELL.
- Loop mode: no gap between sweeps. Step 3's sample cycle is followed directly by step 0, and done never pulses.
- The gate lane must settle within one clock. Stimulus changes only at step boundaries.

## Configuration
- GATE_SEQ_SELFCHECK_EN defined: comparator logic is present, and err/err_step behave as described above.
- GATE_SEQ_SELFCHECK_EN undefined: there is no comparator, and err and err_step are tied to 0.
- Sequencing, result capture, busy and done are identical in both builds.

## Test plan
All scenarios use DWELL=4 with a correct gate model attached, unless stated otherwise.
- rst high 2 cycles, then low -> all outputs 0, state IDLE; a start on the same cycle as rst is ignored.
- start, loop=0 -> a_out/b_out = 00,01,10,11 for 4 cycles each from cycle 1. result sequence = 0010,0111,0101,1100. done pulses on cycle 17 only. err=0.
- loop=1 -> step wraps 3->0 with no DONE cycle. A stop at cycle 10 -> IDLE at cycle 11, step=0, no done, result holds its last captured value.
- Self-check build, model with q forced to 0 -> err sets after step 1's sample cycle, err_step=01. Step 2 mismatches again, but err_step stays 01. A new start clears err.
- start asserted while busy, and start+stop together in IDLE -> both ignored. rst asserted at cycle 7 mid-sweep -> all outputs return to 0 on the next cycle.

Source files
------------

// File: rtl/gate_sequencer.sv
// Steps a two-input gate lane through 00,01,10,11, dwelling DWELL cycles on each and capturing {m,n,p,q}.
// Define GATE_SEQ_SELFCHECK_EN to compare captures against the truth table and report err/err_step.
module gate_sequencer #(
    parameter int unsigned DWELL = 50_000_000,
    parameter int unsigned DIV_W = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic       a_out,
    output logic       b_out,
    input  logic       m_in,
    input  logic       n_in,
    input  logic       p_in,
    input  logic       q_in,
    output logic [3:0] result,
    output logic [1:0] step,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_step
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic             loop_q, loop_d;
    logic [3:0]       result_q, result_d;
    logic [3:0]       capt;

    assign capt = {m_in, n_in, p_in, q_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            loop_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            loop_q   <= loop_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        loop_d   = loop_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    cnt_d   = '0;
                    step_d  = 2'd0;
                    loop_d  = loop;
                end
            end
            APPLY: begin
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    result_d = capt;
                    if (step_q != 2'd3) begin
                        step_d = step_q + 2'd1;
                    end else if (loop_q) begin
                        step_d = 2'd0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = 2'd0;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over start acceptance and over a coinciding sample cycle.
        if (stop) begin
            state_d  = IDLE;
            cnt_d    = '0;
            step_d   = 2'd0;
            loop_d   = loop_q;
            result_d = result_q;
        end
    end

    assign a_out  = step_q[1];
    assign b_out  = step_q[0];
    assign step   = step_q;
    assign busy   = (state_q == APPLY);
    assign done   = (state_q == DONE);
    assign result = result_q;

`ifdef GATE_SEQ_SELFCHECK_EN
    logic       err_q, err_d;
    logic [1:0] err_step_q, err_step_d;
    logic [3:0] exp_v;
    logic       sample_ok;
    logic       accept;

    assign exp_v     = {step_q[1] & step_q[0], step_q[1] | step_q[0], ~step_q[1], step_q[1] ^ step_q[0]};
    assign sample_ok = (state_q == APPLY) && (cnt_q == LAST) && !stop;
    assign accept    = (state_q == IDLE) && start && !stop;

    always_comb begin
        err_d      = err_q;
        err_step_d = err_step_q;
        if (accept) begin
            err_d      = 1'b0;
            err_step_d = 2'd0;
        end else if (sample_ok && (capt != exp_v)) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_step_d = step_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_step_q <= 2'd0;
        end else begin
            err_q      <= err_d;
            err_step_q <= err_step_d;
        end
    end

    assign err      = err_q;
    assign err_step = err_step_q;
`else
    assign err      = 1'b0;
    assign err_step = 2'd0;
`endif

endmodule
